// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multi-cycle CPU: sequences IF/ID/EXE/MEM/WB and decodes datapath controls.
// Optional CU_ILLEGAL_OP_EN adds a sticky IllegalOp output and halts on undefined opcodes.
module multicycle_control_unit #(
    parameter int unsigned    OPW     = 6,
    parameter logic [OPW-1:0] HALT_OP = OPW'(6'b111111)
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic [OPW-1:0] Op,
    input  logic           Zero,
    input  logic           Sign,
    output logic           PCWre,
    output logic           IRWre,
    output logic [1:0]     PCSrc,
    output logic           ALUSrcA,
    output logic           ALUSrcB,
    output logic [2:0]     ALUOp,
    output logic           ExtSel,
    output logic           RegWre,
    output logic [1:0]     RegDst,
    output logic           WrRegDSrc,
    output logic           DBDataSrc,
    output logic           mRD,
    output logic           mWR
`ifdef CU_ILLEGAL_OP_EN
    ,
    output logic           IllegalOp
`endif
);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_AND   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_XORI  = OPW'(6'b010011);
    localparam logic [OPW-1:0] OP_SLL   = OPW'(6'b011000);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_SLTIU = OPW'(6'b100111);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b110100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b110101);
    localparam logic [OPW-1:0] OP_BLTZ  = OPW'(6'b110110);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_JR    = OPW'(6'b111001);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b111010);

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_RS   = 2'b10;
    localparam logic [1:0] PC_JUMP = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EXE_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_AL, S_WB_LD, S_HALT
    } state_t;

    state_t state, next_state;

    logic       is_alu, is_br, is_ls, is_jmp, is_halt;
    logic       alu_src_a, alu_src_b, zext;
    logic [2:0] alu_op;
    logic [1:0] rd_sel;
    logic       take_br;

    // Opcode class and ALU-instruction field decode
    always_comb begin
        is_alu    = 1'b0;
        is_br     = 1'b0;
        is_ls     = 1'b0;
        is_jmp    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        zext      = 1'b0;
        alu_op    = ALU_ADD;
        rd_sel    = RD_RD;
        case (Op)
            OP_ADD:   is_alu = 1'b1;
            OP_SUB:   begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_ADDIU: begin is_alu = 1'b1; alu_src_b = 1'b1; rd_sel = RD_RT; end
            OP_AND:   begin is_alu = 1'b1; alu_op = ALU_AND; end
            OP_ANDI:  begin is_alu = 1'b1; alu_op = ALU_AND; alu_src_b = 1'b1; zext = 1'b1; rd_sel = RD_RT; end
            OP_ORI:   begin is_alu = 1'b1; alu_op = ALU_OR; alu_src_b = 1'b1; zext = 1'b1; rd_sel = RD_RT; end
            OP_XORI:  begin is_alu = 1'b1; alu_op = ALU_XOR; alu_src_b = 1'b1; zext = 1'b1; rd_sel = RD_RT; end
            OP_SLL:   begin is_alu = 1'b1; alu_op = ALU_SLL; alu_src_a = 1'b1; end
            OP_SLT:   begin is_alu = 1'b1; alu_op = ALU_SLT; end
            OP_SLTIU: begin is_alu = 1'b1; alu_op = ALU_SLTU; alu_src_b = 1'b1; zext = 1'b1; rd_sel = RD_RT; end
            OP_SW, OP_LW:            is_ls  = 1'b1;
            OP_BEQ, OP_BNE, OP_BLTZ: is_br  = 1'b1;
            OP_J, OP_JR, OP_JAL:     is_jmp = 1'b1;
            default: ;
        endcase
    end

    assign is_halt = (Op == HALT_OP);
    assign take_br = ((Op == OP_BEQ) & Zero) | ((Op == OP_BNE) & ~Zero) | ((Op == OP_BLTZ) & Sign);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= S_IF;
        else       state <= next_state;
    end

    // Next state and per-state controls; everything is forced low while Reset is held
    always_comb begin
        next_state = state;
        PCWre      = 1'b0;
        IRWre      = 1'b0;
        PCSrc      = PC_SEQ;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        ALUOp      = ALU_ADD;
        ExtSel     = 1'b0;
        RegWre     = 1'b0;
        RegDst     = RD_RA;
        WrRegDSrc  = 1'b0;
        DBDataSrc  = 1'b0;
        mRD        = 1'b0;
        mWR        = 1'b0;
        if (!Reset) begin
            ExtSel = ~zext;
            case (state)
                S_IF: begin
                    IRWre      = 1'b1;
                    next_state = S_ID;
                end
                S_ID: begin
                    if (is_halt)     next_state = S_HALT;
                    else if (is_alu) next_state = S_EXE_AL;
                    else if (is_br)  next_state = S_EXE_BR;
                    else if (is_ls)  next_state = S_EXE_LS;
                    else if (is_jmp) begin
                        next_state = S_IF;
                        PCWre      = 1'b1;
                        PCSrc      = (Op == OP_JR) ? PC_RS : PC_JUMP;
                        if (Op == OP_JAL) begin
                            RegWre    = 1'b1;
                            RegDst    = RD_RA;
                            WrRegDSrc = 1'b0;
                        end
                    end else begin
`ifdef CU_ILLEGAL_OP_EN
                        next_state = S_HALT;
`else
                        next_state = S_IF;
                        PCWre      = 1'b1;
`endif
                    end
                end
                S_EXE_AL: begin
                    ALUSrcA    = alu_src_a;
                    ALUSrcB    = alu_src_b;
                    ALUOp      = alu_op;
                    next_state = S_WB_AL;
                end
                S_WB_AL: begin
                    ALUSrcA    = alu_src_a;
                    ALUSrcB    = alu_src_b;
                    ALUOp      = alu_op;
                    RegWre     = 1'b1;
                    RegDst     = rd_sel;
                    WrRegDSrc  = 1'b1;
                    PCWre      = 1'b1;
                    next_state = S_IF;
                end
                S_EXE_BR: begin
                    ALUOp      = ALU_SUB;
                    PCWre      = 1'b1;
                    PCSrc      = take_br ? PC_BR : PC_SEQ;
                    next_state = S_IF;
                end
                S_EXE_LS: begin
                    ALUOp      = ALU_ADD;
                    ALUSrcB    = 1'b1;
                    next_state = S_MEM;
                end
                S_MEM: begin
                    ALUSrcB = 1'b1;
                    if (Op == OP_LW) begin
                        mRD        = 1'b1;
                        next_state = S_WB_LD;
                    end else begin
                        mWR        = (Op == OP_SW);
                        PCWre      = 1'b1;
                        next_state = S_IF;
                    end
                end
                S_WB_LD: begin
                    ALUSrcB    = 1'b1;
                    RegWre     = 1'b1;
                    RegDst     = RD_RT;
                    WrRegDSrc  = 1'b1;
                    DBDataSrc  = 1'b1;
                    PCWre      = 1'b1;
                    next_state = S_IF;
                end
                S_HALT:  next_state = S_HALT;
                default: next_state = S_IF;
            endcase
        end
    end

`ifdef CU_ILLEGAL_OP_EN
    logic legal;
    logic illegal_q;

    assign legal = is_alu | is_br | is_ls | is_jmp | is_halt;

    // Sticky flag: set when an undefined opcode is decoded, cleared only by Reset
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)                          illegal_q <= 1'b0;
        else if (state == S_ID && !legal)   illegal_q <= 1'b1;
    end

    assign IllegalOp = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: driver queues per-cycle expectations, monitor checks on negedge.
module tb_multicycle_control_unit;

    logic       CLK;
    logic       Reset;
    logic [5:0] Op;
    logic       Zero, Sign;
    logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp;
    logic       ill_act;
    logic [17:0] act;

    multicycle_control_unit dut (
        .CLK(CLK), .Reset(Reset), .Op(Op), .Zero(Zero), .Sign(Sign),
        .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ExtSel(ExtSel), .RegWre(RegWre), .RegDst(RegDst),
        .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR)
`ifdef CU_ILLEGAL_OP_EN
        , .IllegalOp(ill_act)
`endif
    );

`ifndef CU_ILLEGAL_OP_EN
    assign ill_act = 1'b0;
`endif

    assign act = {ill_act, PCWre, IRWre, PCSrc, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
                  RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR};

    // Bit layout: [17]ill [16]PCWre [15]IRWre [14:13]PCSrc [12]ASA [11]ASB [10:8]ALUOp
    //             [7]ExtSel [6]RegWre [5:4]RegDst [3]WrRegDSrc [2]DBDataSrc [1]mRD [0]mWR
    localparam logic [17:0] CM  = 18'b111110000001000011;
    localparam logic [17:0] AM  = 18'b000001111110000000;
    localparam logic [17:0] WM  = 18'b000000000000111100;
    localparam logic [17:0] WJ  = 18'b000000000000111000;
    localparam logic [17:0] ALL = '1;
    localparam logic [17:0] IFV = 18'h08000;
    localparam logic [17:0] ILL = 18'h20000;

    typedef struct {
        string       name;
        logic [17:0] val;
        logic [17:0] msk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [17:0] C(logic pcw, logic irw, logic [1:0] pcs, logic rw, logic mrd, logic mwr);
        return {1'b0, pcw, irw, pcs, 5'b0, 1'b0, rw, 4'b0, mrd, mwr};
    endfunction

    function automatic logic [17:0] A(logic asa, logic asb, logic [2:0] aop, logic ext);
        return {5'b0, asa, asb, aop, ext, 7'b0};
    endfunction

    function automatic logic [17:0] W(logic [1:0] rd, logic wrs, logic dbs);
        return {12'b0, rd, wrs, dbs, 2'b0};
    endfunction

    // Monitor: one expectation per cycle, compared under its mask
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if ((act & e.msk) !== (e.val & e.msk)) begin
                bad++;
                $display("FAIL %s: got %b want %b (mask %b)", e.name, act & e.msk, e.val & e.msk, e.msk);
            end
        end
    end

    task automatic step(input string n, input logic [17:0] v, input logic [17:0] m);
        exp_t e;
        e.name = n;
        e.val  = v;
        e.msk  = m;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_alu(input string n, input logic [5:0] o, input logic asa, input logic asb,
                           input logic [2:0] aop, input logic ext, input logic [1:0] rd);
        Op = o;
        step({n, "_if"},  IFV, CM);
        step({n, "_id"},  '0, CM);
        step({n, "_exe"}, A(asa, asb, aop, ext), CM | AM);
        step({n, "_wb"},  C(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0) | W(rd, 1'b1, 1'b0), CM | WM);
    endtask

    task automatic run_br(input string n, input logic [5:0] o, input logic z, input logic s,
                          input logic [1:0] pcs);
        Op = o; Zero = ~z; Sign = ~s;
        step({n, "_if"}, IFV, CM);
        step({n, "_id"}, '0, CM);
        Zero = z; Sign = s;
        step({n, "_exe"}, C(1'b1, 1'b0, pcs, 1'b0, 1'b0, 1'b0) | A(1'b0, 1'b0, 3'b001, 1'b1), CM | AM);
        Zero = 1'b0; Sign = 1'b0;
    endtask

    task automatic run_mem(input string n, input logic lw);
        Op = lw ? 6'b110001 : 6'b110000;
        step({n, "_if"},  IFV, CM);
        step({n, "_id"},  '0, CM);
        step({n, "_exe"}, A(1'b0, 1'b1, 3'b000, 1'b1), CM | AM);
        if (lw) begin
            step({n, "_mem"}, C(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0), CM);
            step({n, "_wb"},  C(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0) | W(2'b01, 1'b1, 1'b1), CM | WM);
        end else begin
            step({n, "_mem"}, C(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1), CM);
        end
    endtask

    task automatic run_j(input string n, input logic [5:0] o, input logic [1:0] pcs, input logic rw);
        Op = o;
        step({n, "_if"}, IFV, CM);
        step({n, "_id"}, C(1'b1, 1'b0, pcs, rw, 1'b0, 1'b0), rw ? (CM | WJ) : CM);
    endtask

    initial begin : driver
        Reset = 1'b1; Op = 6'b000000; Zero = 1'b0; Sign = 1'b0;
        @(posedge CLK);
        #1;
        step("reset_a", '0, ALL);
        step("reset_b", '0, ALL);
        Reset = 1'b0;

        // Reset asserted during EXE_AL of an ADD: abandon, no write-back
        Op = 6'b000000;
        step("t1_if", IFV, CM);
        step("t1_id", '0, CM);
        Zero = 1'b1; Sign = 1'b1; Reset = 1'b1;
        step("t1_rst0", '0, ALL);
        step("t1_rst1", '0, ALL);
        Zero = 1'b0; Sign = 1'b0; Reset = 1'b0;

        run_alu("add",   6'b000000, 1'b0, 1'b0, 3'b000, 1'b1, 2'b10);
        run_alu("sub",   6'b000001, 1'b0, 1'b0, 3'b001, 1'b1, 2'b10);
        run_alu("addiu", 6'b000010, 1'b0, 1'b1, 3'b000, 1'b1, 2'b01);
        run_alu("and",   6'b010000, 1'b0, 1'b0, 3'b100, 1'b1, 2'b10);
        run_alu("andi",  6'b010001, 1'b0, 1'b1, 3'b100, 1'b0, 2'b01);
        run_alu("ori",   6'b010010, 1'b0, 1'b1, 3'b011, 1'b0, 2'b01);
        run_alu("xori",  6'b010011, 1'b0, 1'b1, 3'b111, 1'b0, 2'b01);
        run_alu("sll",   6'b011000, 1'b1, 1'b0, 3'b010, 1'b1, 2'b10);
        run_alu("slt",   6'b100110, 1'b0, 1'b0, 3'b110, 1'b1, 2'b10);
        run_alu("sltiu", 6'b100111, 1'b0, 1'b1, 3'b101, 1'b0, 2'b01);

        run_br("beq_t",  6'b110100, 1'b1, 1'b0, 2'b01);
        run_br("beq_n",  6'b110100, 1'b0, 1'b1, 2'b00);
        run_br("bne_t",  6'b110101, 1'b0, 1'b0, 2'b01);
        run_br("bne_n",  6'b110101, 1'b1, 1'b1, 2'b00);
        run_br("bltz_t", 6'b110110, 1'b0, 1'b1, 2'b01);
        run_br("bltz_n", 6'b110110, 1'b1, 1'b0, 2'b00);

        run_mem("lw", 1'b1);
        run_mem("sw", 1'b0);

        run_j("jal", 6'b111010, 2'b11, 1'b1);
        run_j("jr",  6'b111001, 2'b10, 1'b0);
        run_j("j",   6'b111000, 2'b11, 1'b0);

        // HALT parks the FSM with no fetch and no PC load
        Op = 6'b111111;
        step("halt_if", IFV, CM);
        step("halt_id", '0, CM);
        for (int i = 0; i < 20; i++) step("halt_park", '0, CM);
        Reset = 1'b1;
        step("halt_rst", '0, ALL);
        Reset = 1'b0;
        run_j("j_after_halt", 6'b111000, 2'b11, 1'b0);

        // Undefined opcode
        Op = 6'b101010;
        step("ill_if", IFV, CM);
`ifdef CU_ILLEGAL_OP_EN
        step("ill_id", '0, CM);
        for (int i = 0; i < 4; i++) step("ill_halt", ILL, CM);
        Reset = 1'b1;
        step("ill_rst", '0, ALL);
        Reset = 1'b0;
`else
        step("ill_nop", C(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0), CM);
`endif
        run_alu("add_end", 6'b000000, 1'b0, 1'b0, 3'b000, 1'b1, 2'b10);

        repeat (2) @(posedge CLK);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
